// File: rtl/datapath_gray_arbiter_if.sv
`default_nettype none
// datapath_gray_arbiter_if: two byte sources, the datapath input stream and datapath output observation.
// Rev 1.0
interface datapath_gray_arbiter_if;
  logic [7:0] s0_data;
  logic       s0_valid;
  logic       s0_sof;
  logic       s0_busy;
  logic [7:0] s1_data;
  logic       s1_valid;
  logic       s1_sof;
  logic       s1_busy;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_sof;
  logic       m_busy;
  logic       dp_valid;
  logic       dp_sof;

  modport slave (
    input  s0_data, s0_valid, s0_sof,
    output s0_busy,
    input  s1_data, s1_valid, s1_sof,
    output s1_busy,
    output m_data, m_valid, m_sof,
    input  m_busy,
    input  dp_valid, dp_sof
  );

  modport master (
    output s0_data, s0_valid, s0_sof,
    input  s0_busy,
    output s1_data, s1_valid, s1_sof,
    input  s1_busy,
    input  m_data, m_valid, m_sof,
    output m_busy,
    output dp_valid, dp_sof
  );
endinterface
`default_nettype wire

// File: rtl/datapath_gray_arbiter.sv
`default_nettype none
// datapath_gray_arbiter: round-robin frame arbiter for two byte sources with owner-ID tracking.
// Rev 1.0
module datapath_gray_arbiter #(
  parameter int C_FRAME_BYTES = 192,
  parameter int C_ID_DEPTH    = 4
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst,
  datapath_gray_arbiter_if.slave bus,
  output logic                   o_src_id,
  output logic [2:0]             o_err
);
  localparam int CNT_W = $clog2(C_FRAME_BYTES + 1);
  localparam int PTR_W = (C_ID_DEPTH > 1) ? $clog2(C_ID_DEPTH) : 1;
  localparam int OCC_W = $clog2(C_ID_DEPTH + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(C_FRAME_BYTES);
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(C_ID_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    rr_ptr, rr_nxt;
  logic [C_ID_DEPTH-1:0]   fifo_mem;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [OCC_W-1:0]        occ;
  logic                    fifo_full, fifo_empty;
  logic                    push, push_id, pop, pop_empty;
  logic                    stray, restart;
  logic                    req0, req1, sel;
  logic                    sel_valid, sel_sof;
  logic [7:0]              sel_data;

  assign fifo_full  = (occ == OCC_FULL);
  assign fifo_empty = (occ == '0);
  assign pop        = bus.dp_valid & bus.dp_sof & ~fifo_empty;
  assign pop_empty  = bus.dp_valid & bus.dp_sof & fifo_empty;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rr_nxt      = rr_ptr;
    bus.s0_busy = 1'b1;
    bus.s1_busy = 1'b1;
    bus.m_data  = '0;
    bus.m_valid = 1'b0;
    bus.m_sof   = 1'b0;
    push        = 1'b0;
    push_id     = 1'b0;
    stray       = 1'b0;
    restart     = 1'b0;
    req0        = bus.s0_valid & bus.s0_sof;
    req1        = bus.s1_valid & bus.s1_sof;
    sel         = (state == GRANT1);
    sel_valid   = sel ? bus.s1_valid : bus.s0_valid;
    sel_sof     = sel ? bus.s1_sof   : bus.s0_sof;
    sel_data    = sel ? bus.s1_data  : bus.s0_data;
    // Reset overrides the state decode so a frame in flight stops immediately.
    if (!i_rst) begin
      unique case (state)
        IDLE: begin
          if (bus.s0_valid && !bus.s0_sof) begin
            bus.s0_busy = 1'b0;
            stray       = 1'b1;
          end
          if (bus.s1_valid && !bus.s1_sof) begin
            bus.s1_busy = 1'b0;
            stray       = 1'b1;
          end
          if ((req0 || req1) && !fifo_full) begin
            push      = 1'b1;
            push_id   = (req0 && req1) ? rr_ptr : req1;
            rr_nxt    = ~push_id;
            cnt_nxt   = '0;
            state_nxt = push_id ? GRANT1 : GRANT0;
          end
        end
        GRANT0, GRANT1: begin
          bus.m_data  = sel_data;
          bus.m_valid = sel_valid;
          bus.m_sof   = sel_sof;
          if (sel) bus.s1_busy = bus.m_busy;
          else     bus.s0_busy = bus.m_busy;
          if (sel_valid && !bus.m_busy) begin
            // A second sof inside a frame restarts the count for the same owner.
            if (sel_sof && (cnt != '0)) begin
              restart = 1'b1;
              cnt_nxt = CNT_W'(1);
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
              if (cnt_nxt == FRAME_LAST) state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      o_src_id <= 1'b0;
      o_err    <= 3'b000;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rr_ptr <= rr_nxt;
      if (push) begin
        fifo_mem[wr_ptr] <= push_id;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        o_src_id <= fifo_mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      o_err <= o_err | {pop_empty, restart, stray};
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_datapath_gray_arbiter.sv
`default_nettype none
// tb_datapath_gray_arbiter: scoreboard bench for the two-source frame arbiter.
// Rev 1.0
module tb_datapath_gray_arbiter;
  localparam int FRAME = 192;
  localparam int WAIT_LIMIT = 3000;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       o_src_id;
  logic [2:0] o_err;
  int         errors = 0;
  int         checks = 0;

  datapath_gray_arbiter_if bus ();

  datapath_gray_arbiter #(
    .C_FRAME_BYTES(FRAME),
    .C_ID_DEPTH   (4)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .bus     (bus),
    .o_src_id(o_src_id),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Expected entries are {last, sof, data}; owner_q holds the bench's grant order.
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int         owner_q[$];
  bit         mb_toggle = 1'b0;
  bit         active = 1'b0;
  int         cur = 0;
  int         w0, w1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_src(input int s, input logic v, input logic f, input logic [7:0] d);
    if (s == 0) begin
      bus.s0_valid = v; bus.s0_sof = f; bus.s0_data = d;
    end else begin
      bus.s1_valid = v; bus.s1_sof = f; bus.s1_data = d;
    end
  endtask

  function automatic logic src_busy(input int s);
    return (s == 0) ? bus.s0_busy : bus.s1_busy;
  endfunction

  task automatic send_frame(input int s, input int nbytes, input int sof_at,
                            input int abort_at, output int first_wait);
    logic [7:0] d;
    logic       sf;
    int         waits;
    first_wait = 0;
    for (int i = 1; i <= nbytes; i++) begin
      d  = 8'($urandom_range(0, 255));
      sf = (i == 1) || (i == sof_at);
      drive_src(s, 1'b1, sf, d);
      if (i == abort_at) begin
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        drive_src(s, 1'b0, 1'b0, 8'h00);
        return;
      end
      if (s == 0) q0.push_back({(i == nbytes), sf, d});
      else        q1.push_back({(i == nbytes), sf, d});
      waits = 0;
      @(negedge i_clk);
      while (src_busy(s) && waits < WAIT_LIMIT) begin
        waits++;
        @(negedge i_clk);
      end
      if (waits >= WAIT_LIMIT) begin
        check("byte_handshake_timeout", waits, 0);
        drive_src(s, 1'b0, 1'b0, 8'h00);
        @(posedge i_clk); #1;
        return;
      end
      if (i == 1) first_wait = waits;
      @(posedge i_clk); #1;
    end
    drive_src(s, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pulse_dp();
    bus.dp_valid = 1'b1;
    bus.dp_sof   = 1'b1;
    @(posedge i_clk); #1;
    bus.dp_valid = 1'b0;
    bus.dp_sof   = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    q0.delete(); q1.delete(); owner_q.delete();
    @(negedge i_clk);
    check("rst_err", o_err, 3'b000);
    check("rst_src_id", o_src_id, 1'b0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    bus.m_busy = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      bus.m_busy = mb_toggle ? ~bus.m_busy : 1'b0;
    end
  end

  // Output monitor: pops the expected byte of the bench-chosen owner on every accepted byte.
  always @(negedge i_clk) begin
    logic [9:0] e;
    if (i_rst) begin
      active = 1'b0;
      check("rst_m_valid", bus.m_valid, 1'b0);
      check("rst_busy", {bus.s0_busy, bus.s1_busy}, 2'b11);
    end else begin
      if (bus.m_valid && !bus.m_busy && !active) begin
        check("owner_expected", owner_q.size() != 0, 1'b1);
        if (owner_q.size() != 0) begin
          cur    = owner_q.pop_front();
          active = 1'b1;
        end
      end
      if (active) check("other_src_busy", (cur == 0) ? bus.s1_busy : bus.s0_busy, 1'b1);
      if (active && bus.m_valid && !bus.m_busy) begin
        check("byte_expected", ((cur == 0) ? q0.size() : q1.size()) != 0, 1'b1);
        if (((cur == 0) ? q0.size() : q1.size()) != 0) begin
          e = (cur == 0) ? q0.pop_front() : q1.pop_front();
          check("m_data", bus.m_data, e[7:0]);
          check("m_sof", bus.m_sof, e[8]);
          if (e[9]) active = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.s0_valid = 0; bus.s0_sof = 0; bus.s0_data = 0;
    bus.s1_valid = 0; bus.s1_sof = 0; bus.s1_data = 0;
    bus.dp_valid = 0; bus.dp_sof = 0;
    @(posedge i_clk); #1;
    do_reset();

    // Single s0 frame, then pop its owner ID.
    owner_q.push_back(0);
    send_frame(0, FRAME, 0, 0, w0);
    check("t1_grant_latency", w0, 1);
    @(negedge i_clk);
    check("t1_idle_after_frame", {bus.s0_busy, bus.m_valid}, 2'b10);
    @(posedge i_clk); #1;
    pulse_dp();
    @(negedge i_clk);
    check("t1_src_id", o_src_id, 1'b0);
    check("t1_err", o_err, 3'b000);
    @(posedge i_clk); #1;

    // Tie after reset: s0 first, s1 after a one-cycle IDLE gap.
    do_reset();
    owner_q.push_back(0);
    owner_q.push_back(1);
    fork
      send_frame(0, FRAME, 0, 0, w0);
      send_frame(1, FRAME, 0, 0, w1);
    join
    check("t2_s0_latency", w0, 1);
    check("t2_s1_latency", w1, FRAME + 2);

    // Backpressure toggling every cycle.
    mb_toggle = 1'b1;
    owner_q.push_back(0);
    send_frame(0, FRAME, 0, 0, w0);
    mb_toggle = 1'b0;
    @(posedge i_clk); #1;

    // Fourth grant fills the ID FIFO; the fifth request waits for a pop.
    owner_q.push_back(1);
    send_frame(1, FRAME, 0, 0, w1);
    owner_q.push_back(0);
    fork
      send_frame(0, FRAME, 0, 0, w0);
      begin
        repeat (10) @(posedge i_clk);
        #1;
        pulse_dp();
        @(negedge i_clk);
        check("t4_src_id_first", o_src_id, 1'b0);
        check("t4_err", o_err, 3'b000);
      end
    join
    check("t4_held_cycles", w0, 12);
    pulse_dp();
    @(negedge i_clk);
    check("t4_src_id_second", o_src_id, 1'b1);
    @(posedge i_clk); #1;

    // Error flags: stray byte, mid-frame sof, empty pop.
    do_reset();
    drive_src(0, 1'b1, 1'b0, 8'h5A);
    @(negedge i_clk);
    check("t5_stray_busy", bus.s0_busy, 1'b0);
    @(posedge i_clk); #1;
    drive_src(0, 1'b0, 1'b0, 8'h00);
    @(negedge i_clk);
    check("t5_err_stray", o_err, 3'b001);
    @(posedge i_clk); #1;
    owner_q.push_back(1);
    send_frame(1, FRAME + 49, 50, 0, w1);
    @(negedge i_clk);
    check("t5_err_restart", o_err, 3'b011);
    check("t5_idle_after_restart", bus.s1_busy, 1'b1);
    @(posedge i_clk); #1;
    pulse_dp();
    @(negedge i_clk);
    check("t5_src_id", o_src_id, 1'b1);
    check("t5_err_pop_ok", o_err, 3'b011);
    @(posedge i_clk); #1;
    pulse_dp();
    @(negedge i_clk);
    check("t5_err_underflow", o_err, 3'b111);
    check("t5_src_id_kept", o_src_id, 1'b1);
    @(posedge i_clk); #1;

    // Reset in the middle of an s1 frame, then a tie goes to s0.
    owner_q.push_back(1);
    send_frame(1, FRAME, 0, 100, w1);
    @(negedge i_clk);
    check("t6_err_cleared", o_err, 3'b000);
    check("t6_src_id_cleared", o_src_id, 1'b0);
    check("t6_idle", {bus.s0_busy, bus.s1_busy, bus.m_valid}, 3'b110);
    @(posedge i_clk); #1;
    owner_q.push_back(0);
    owner_q.push_back(1);
    fork
      send_frame(0, FRAME, 0, 0, w0);
      send_frame(1, FRAME, 0, 0, w1);
    join
    check("t6_s0_wins_tie", w0, 1);
    check("t6_s1_latency", w1, FRAME + 2);

    repeat (3) @(posedge i_clk);
    check("queues_drained", q0.size() + q1.size() + owner_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/datapath_gray_arbiter.md
DATAPATH_GRAY_ARBITER -- requirements
Module: datapath_gray_arbiter

Interface
REQ-001 Parameters SHALL be C_FRAME_BYTES, default 192, accepted bytes per frame (multiple of 3); and C_ID_DEPTH, default 4, owner-ID FIFO depth (power of 2).
REQ-002 i_clk  input  1  the single clock; all logic SHALL be rising-edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 s0_data/s1_data  input  8  source byte.
REQ-005 s0_valid/s1_valid, s0_sof/s1_sof  input  1 each  byte valid and first-byte-of-frame.
REQ-006 s0_busy/s1_busy  output  1 each  source SHALL hold its byte while high.
REQ-007 m_data  output  8, m_valid  output  1, m_sof  output  1  stream to the datapath input.
REQ-008 m_busy  input  1  datapath busy_out.
REQ-009 dp_valid  input  1, dp_sof  input  1  datapath valid_out/sof_out, observed only.
REQ-010 o_src_id  output  1  owner of the frame currently leaving the datapath.
REQ-011 o_err  output  3  sticky errors: [0] stray byte, [1] mid-frame sof, [2] ID underflow.

Function
REQ-012 The FSM SHALL have states IDLE, GRANT0 and GRANT1.
REQ-013 In IDLE, s0_busy and s1_busy SHALL both be 1 unless REQ-017 applies, and m_valid SHALL be 0.
REQ-014 In IDLE, a source SHALL be requesting when valid=1 and sof=1.
REQ-015 From IDLE, with ID FIFO not full, a single requester x SHALL move the FSM to GRANTx on the next cycle.
REQ-016 On simultaneous requests, the source not granted last SHALL win (round-robin); the pointer after reset SHALL favour s0.
REQ-017 In IDLE, a source with valid=1 and sof=0 SHALL see busy=0 so the byte is dropped, and o_err[0] SHALL set.
REQ-018 On the IDLE->GRANTx transition, the FIFO SHALL push x and the byte counter SHALL clear.
REQ-019 With ID FIFO full, IDLE SHALL persist and requests SHALL be held.
REQ-020 In GRANTx, m_data/m_valid/m_sof SHALL combinationally equal source x's signals.
REQ-021 In GRANTx, sx_busy SHALL equal m_busy and the other source's busy SHALL be 1.
REQ-022 An accepted byte SHALL be m_valid=1 and m_busy=0; only accepted bytes SHALL increment the counter.
REQ-023 The counter SHALL be $clog2(C_FRAME_BYTES+1) bits wide and SHALL never wrap.
REQ-024 The accepted byte that brings the count to C_FRAME_BYTES SHALL return the FSM to IDLE next cycle; IDLE SHALL last at least one cycle between frames.
REQ-025 An accepted byte with sof=1 in GRANTx other than the frame's first SHALL set o_err[1] and set the counter to 1 (frame restart, same owner, no FIFO push).
REQ-026 A cycle with dp_valid=1 and dp_sof=1 SHALL pop the FIFO and register the head into o_src_id next cycle.
REQ-027 A pop of an empty FIFO SHALL set o_err[2] and leave o_src_id unchanged.
REQ-028 A simultaneous push and pop SHALL both take effect, with occupancy unchanged.
REQ-029 o_err bits SHALL clear only on reset.

Reset
REQ-030 While i_rst=1 at a clock edge, the next state SHALL be: IDLE, counter 0, FIFO empty, RR pointer favouring s0, o_src_id=0, o_err=0.
REQ-031 During reset, busy outputs SHALL be 1 and m_valid 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no further m_valid until a new grant.

Verification
REQ-033 Scenario: s0 sends a 192-byte frame, m_busy=0 -> GRANT0 one cycle after sof; 192 bytes forwarded; IDLE after the 192nd byte; FIFO holds 0.
REQ-034 Scenario: s0 and s1 raise sof in the same IDLE cycle after reset -> s0 frame first, s1 held busy=1, then s1 granted after a 1-cycle IDLE gap.
REQ-035 Scenario: m_busy toggles every other cycle during a frame -> exactly 192 accepted bytes, no loss or duplication, and s1_busy=1 throughout.
REQ-036 Scenario: 4 frames granted with no dp_sof -> 5th request held in IDLE; one dp_valid&dp_sof pulse -> grant proceeds and o_src_id shows the first owner.
REQ-037 Scenario: stray byte in IDLE sets o_err=3'b001; sof at byte 50 sets o_err[1] and the frame then ends 191 accepted bytes later; dp_sof with empty FIFO sets o_err[2].
REQ-038 Scenario: i_rst asserted at byte 100 of an s1 frame -> next cycle IDLE, o_err=0, o_src_id=0, and s0 wins the next tie.
